// File: rtl/imm_gen_q_pkg.sv
// Shared types and opcode constants for the buffered immediate generator.
// Optional MOVZ/MOVK decode is enabled by defining IMM_GEN_MOVZ_EN.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_B    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_D    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } imm_fmt_t;

    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;

endpackage

// File: rtl/imm_gen_q_if.sv
// Valid/ready bundle between decode, the immediate queue and execute.
// slave = the queue itself, master = the surrounding pipeline.
interface imm_gen_q_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_fmt;
    logic              out_err;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_err, out_tag
    );

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_err, out_tag
    );
endinterface

// File: rtl/imm_gen_q_decode.sv
// Combinational LEGv8 immediate decoder; formats are mutually exclusive.
// IW (MOVZ/MOVK) decode exists only when IMM_GEN_MOVZ_EN is defined.
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       instr_i,
    output logic [DATA_W-1:0] imm_o,
    output imm_fmt_t          fmt_o,
    output logic              err_o
);
    logic is_cb;
    logic is_b;
    logic is_d;
    logic is_i;
    logic is_iw;
    logic [DATA_W-1:0] iw_imm;
    logic unused_bits;

    assign is_cb = (instr_i[31:24] == OP_CBZ) || (instr_i[31:24] == OP_CBNZ);
    assign is_b  = (instr_i[31:26] == OP_B);
    assign is_d  = (instr_i[31:21] == OP_LDUR) || (instr_i[31:21] == OP_STUR);
    assign is_i  = (instr_i[31:22] == OP_ADDI)  || (instr_i[31:22] == OP_ADDIS)
                || (instr_i[31:22] == OP_SUBI)  || (instr_i[31:22] == OP_SUBIS);
`ifdef IMM_GEN_MOVZ_EN
    assign is_iw  = (instr_i[31:23] == OP_MOVZ) || (instr_i[31:23] == OP_MOVK);
    // Shifting at DATA_W width drops the half-words that do not fit.
    assign iw_imm = {{(DATA_W-16){1'b0}}, instr_i[20:5]}
                    << {instr_i[22:21], 4'd0};
`else
    assign is_iw  = 1'b0;
    assign iw_imm = '0;
`endif
    assign unused_bits = ^instr_i[4:0];

    // Select and sign-extend the field of the matching format.
    always_comb begin
        imm_o = '0;
        fmt_o = FMT_NONE;
        err_o = 1'b1;
        unique case (1'b1)
            is_cb: begin
                imm_o = {{(DATA_W-19){instr_i[23]}}, instr_i[23:5]};
                fmt_o = FMT_CB;
                err_o = 1'b0;
            end
            is_b: begin
                imm_o = {{(DATA_W-26){instr_i[25]}}, instr_i[25:0]};
                fmt_o = FMT_B;
                err_o = 1'b0;
            end
            is_d: begin
                imm_o = {{(DATA_W-9){instr_i[20]}}, instr_i[20:12]};
                fmt_o = FMT_D;
                err_o = 1'b0;
            end
            is_i: begin
                imm_o = {{(DATA_W-12){instr_i[21]}}, instr_i[21:10]};
                fmt_o = FMT_I;
                err_o = 1'b0;
            end
            is_iw: begin
                imm_o = iw_imm;
                fmt_o = FMT_IW;
                err_o = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/imm_gen_q.sv
// Buffered immediate generator: decode followed by a BUF_DEPTH-entry FIFO.
// Define IMM_GEN_MOVZ_EN to add MOVZ/MOVK (IW) decoding.
module imm_gen_q
    import imm_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    imm_gen_q_if.slave   bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        imm_fmt_t          fmt;
        logic              err;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    logic [DATA_W-1:0] dec_imm;
    imm_fmt_t          dec_fmt;
    logic              dec_err;
    entry_t            wr_e;
    entry_t            head_e;

    entry_t          mem_q [BUF_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   head_idx;
    logic            push;
    logic            pop;

    imm_decode #(.DATA_W(DATA_W)) u_dec (
        .instr_i (bus.in_instr),
        .imm_o   (dec_imm),
        .fmt_o   (dec_fmt),
        .err_o   (dec_err)
    );

    assign wr_e = '{imm: dec_imm, fmt: dec_fmt, err: dec_err, tag: bus.in_tag};

    assign bus.in_ready  = (cnt_q != CW'(BUF_DEPTH));
    assign bus.out_valid = (cnt_q != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // When empty, show the slot just popped so outputs keep the last entry.
    assign head_idx = bus.out_valid ? rd_ptr_q : rd_ptr_q - AW'(1);
    assign head_e   = mem_q[head_idx];

    assign bus.out_imm = head_e.imm;
    assign bus.out_fmt = head_e.fmt;
    assign bus.out_err = head_e.err;
    assign bus.out_tag = head_e.tag;

    // Next pointers and occupancy from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    // FIFO state; reset clears storage so outputs are never X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) mem_q[wr_ptr_q] <= wr_e;
        end
    end
endmodule

// File: tb/tb_imm_gen_q.sv
// Self-checking bench for imm_gen_q against a queue-based reference model.
// Honours IMM_GEN_MOVZ_EN for the IW expectations.
module tb_imm_gen_q;
    import imm_pkg::*;

    localparam int DW  = 64;
    localparam int TW  = 4;
    localparam int DEP = 2;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   pops;
    exp_t q[$];
    exp_t last_e;

    imm_gen_q_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    imm_gen_q #(.DATA_W(DW), .BUF_DEPTH(DEP), .TAG_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [63:0] sx(logic [31:0] f, int bits);
        longint v;
        v = longint'(f);
        if (v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 64'(v);
    endfunction

    function automatic exp_t model(logic [31:0] w, logic [3:0] t);
        exp_t e;
        logic [63:0] a;
        e.tag = t;
        e.err = 1'b0;
        a = 64'(w[20:5]);
        if (w[31:25] == 7'b1011010) begin
            e.imm = sx(32'(w[23:5]), 19); e.fmt = FMT_CB;
        end else if (w[31:26] == 6'b000101) begin
            e.imm = sx(32'(w[25:0]), 26); e.fmt = FMT_B;
        end else if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
            e.imm = sx(32'(w[20:12]), 9); e.fmt = FMT_D;
        end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1011000100 ||
                     w[31:22] == 10'b1101000100 || w[31:22] == 10'b1111000100) begin
            e.imm = sx(32'(w[21:10]), 12); e.fmt = FMT_I;
`ifdef IMM_GEN_MOVZ_EN
        end else if (w[31:23] == 9'b110100101 || w[31:23] == 9'b111100101) begin
            e.imm = a * (64'd1 << (16 * int'(w[22:21]))); e.fmt = FMT_IW;
`endif
        end else begin
            e.imm = '0; e.fmt = FMT_NONE; e.err = 1'b1;
        end
        if (a == 64'hFFFF_FFFF) e.err = 1'b1;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Reference model update on each active edge.
    always @(posedge clk) begin
        if (reset_n) begin
            bit pu;
            bit po;
            pu = bus.in_valid && (q.size() < DEP);
            po = bus.out_ready && (q.size() > 0);
            if (po) begin
                last_e = q.pop_front();
                pops++;
            end
            if (pu) q.push_back(model(bus.in_instr, bus.in_tag));
        end
    end

    // Asynchronous reset discards everything the model holds.
    always @(negedge reset_n) begin
        q.delete();
        last_e = '{imm: 64'd0, fmt: 3'd0, err: 1'b0, tag: 4'd0};
    end

    // Compare all outputs every cycle on the inactive edge.
    always @(negedge clk) begin
        if (reset_n) begin
            exp_t e;
            logic ev;
            logic er;
            e  = (q.size() != 0) ? q[0] : last_e;
            ev = (q.size() != 0);
            er = (q.size() != DEP);
            checks++;
            if (bus.out_valid !== ev || bus.in_ready !== er ||
                bus.out_imm !== e.imm || bus.out_fmt !== e.fmt ||
                bus.out_err !== e.err || bus.out_tag !== e.tag) begin
                errors++;
                $display("FAIL cmp t=%0t got v=%b r=%b imm=%h f=%0d e=%b t=%0d want v=%b r=%b imm=%h f=%0d e=%b t=%0d",
                         $time, bus.out_valid, bus.in_ready, bus.out_imm,
                         bus.out_fmt, bus.out_err, bus.out_tag,
                         ev, er, e.imm, e.fmt, e.err, e.tag);
            end
        end
    end

    task automatic one(logic [31:0] w, logic [3:0] t, logic [63:0] ei,
                       logic [2:0] ef, logic ee, string nm);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_instr  = w;
        bus.in_tag    = t;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({nm, "_v"},   64'(bus.out_valid), 64'd1);
        chk({nm, "_imm"}, bus.out_imm, ei);
        chk({nm, "_fmt"}, 64'(bus.out_fmt), 64'(ef));
        chk({nm, "_err"}, 64'(bus.out_err), 64'(ee));
        chk({nm, "_tag"}, 64'(bus.out_tag), 64'(t));
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] r;
        logic [1:0]  s;
        r = $urandom;
        s = 2'($urandom);
        case ($urandom_range(0, 6))
            0: return {7'b1011010, r[24:0]};
            1: return {6'b000101, r[25:0]};
            2: return {10'b1111100000, s[0], 1'b0, r[19:0]};
            3: return {s[1:0], 8'b01000100, r[21:0]};
            4: return {1'b1, s[0], 7'b1100101, r[22:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        exp_t m;
        int p0;
        checks = 0;
        errors = 0;
        pops   = 0;
        reset_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        m = model(32'hB40002E1, 4'd0);
        chk("pin_cbz", m.imm, 64'd23);
        m = model(32'hF85E9000, 4'd0);
        chk("pin_ldur", m.imm, 64'hFFFF_FFFF_FFFF_FFE9);
        m = model(32'h17FFFFFF, 4'd0);
        chk("pin_b", m.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        m = model(32'h98017001, 4'd0);
        chk("pin_unk", 64'(m.err), 64'd1);

        @(negedge clk);
        chk("rst_v",   64'(bus.out_valid), 64'd0);
        chk("rst_r",   64'(bus.in_ready), 64'd1);
        chk("rst_imm", bus.out_imm, 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        #2 reset_n = 1'b1;

        one(32'hB40002E1, 4'd1, 64'd23, FMT_CB, 1'b0, "cbz");
        one(32'hB4FFFD21, 4'd2, 64'hFFFF_FFFF_FFFF_FFE9, FMT_CB, 1'b0, "cbneg");
        one(32'hF85E9000, 4'd3, 64'hFFFF_FFFF_FFFF_FFE9, FMT_D, 1'b0, "ldur");
        one(32'h91005C00, 4'd4, 64'd23, FMT_I, 1'b0, "addi");
        one(32'h17FFFFFF, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, FMT_B, 1'b0, "b");
        one(32'h98017001, 4'd9, 64'd0, FMT_NONE, 1'b1, "unk");
`ifdef IMM_GEN_MOVZ_EN
        one(32'hD2E24680, 4'd6, 64'h1234_0000_0000_0000, FMT_IW, 1'b0, "movz");
`else
        one(32'hD2E24680, 4'd6, 64'd0, FMT_NONE, 1'b1, "movz");
`endif

        // Backpressure: two fill the FIFO, third waits for a pop.
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h91000000 | (32'(i) << 10);
            bus.in_tag   = 4'(i);
            if (i < 2) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_full", 64'(bus.in_ready), 64'd0);
            chk("bp_head", 64'(bus.out_tag), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_tag1", 64'(bus.out_tag), 64'd1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Full-rate streaming.
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                chk("st_v", 64'(bus.out_valid), 64'd1);
                chk("st_tag", 64'(bus.out_tag), 64'(i - 1));
            end
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h14000000 | 32'(i);
            bus.in_tag   = 4'(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("st_pops", 64'(pops - p0), 64'd16);

        // Async reset with two entries queued.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hB40002E1;
        bus.in_tag    = 4'd7;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_v",   64'(bus.out_valid), 64'd0);
        chk("ar_r",   64'(bus.in_ready), 64'd1);
        chk("ar_imm", bus.out_imm, 64'd0);
        chk("ar_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        one(32'h91005C00, 4'd8, 64'd23, FMT_I, 1'b0, "ar_rel");

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_instr  = rnd_word();
            bus.in_tag    = 4'($urandom);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
